// File: rtl/mat_uart_tx_fmt_pkg.sv
// mat_uart_tx_fmt_pkg: shared FSM encoding, ASCII constants and matrix dimension limit
package mat_uart_tx_fmt_pkg;

    localparam logic [3:0] MAX_DIM   = 4'd5;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_ZERO  = 8'h30;

    typedef enum logic [3:0] {
        IDLE, FETCH, RDWAIT, CONV, EMIT, TXWAIT, SEP, CR, LF, FIN
    } state_t;

endpackage

// File: rtl/mat_uart_tx_fmt_if.sv
// mat_uart_tx_fmt_if: matrix storage read port plus UART transmitter byte handshake
interface mat_uart_tx_fmt_if #(parameter int ELEM_W = 8);

    logic              rd_en;
    logic              rd_slot;
    logic [3:0]        rd_row;
    logic [3:0]        rd_col;
    logic [ELEM_W-1:0] rd_data;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done;

    modport master (
        output rd_en, rd_slot, rd_row, rd_col, tx_start, tx_data,
        input  rd_data, tx_done
    );

    modport slave (
        input  rd_en, rd_slot, rd_row, rd_col, tx_start, tx_data,
        output rd_data, tx_done
    );

endinterface

// File: rtl/mat_uart_tx_fmt_bin2dec_seq.sv
// mat_uart_tx_fmt_bin2dec_seq: iterative 8-bit to 3-digit decimal converter, one subtraction per cycle
module mat_uart_tx_fmt_bin2dec_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    output logic       done,
    output logic [1:0] cnt,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0
);

    logic       busy_q, busy_d;
    logic [7:0] rem_q, rem_d;
    logic [3:0] h_q, h_d, t_q, t_d;

    // peel off hundreds first, then tens; what is left is the units digit
    always_comb begin
        busy_d = busy_q;
        rem_d  = rem_q;
        h_d    = h_q;
        t_d    = t_q;
        if (start) begin
            busy_d = 1'b1;
            rem_d  = din;
            h_d    = 4'd0;
            t_d    = 4'd0;
        end else if (busy_q) begin
            if (rem_q >= 8'd100) begin
                rem_d = rem_q - 8'd100;
                h_d   = h_q + 4'd1;
            end else if (rem_q >= 8'd10) begin
                rem_d = rem_q - 8'd10;
                t_d   = t_q + 4'd1;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    // converter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            rem_q  <= 8'd0;
            h_q    <= 4'd0;
            t_q    <= 4'd0;
        end else begin
            busy_q <= busy_d;
            rem_q  <= rem_d;
            h_q    <= h_d;
            t_q    <= t_d;
        end
    end

    // digits stay valid after done until the next start; leading zeros drop out of cnt
    assign done = busy_q && !start && (rem_q < 8'd10);
    assign cnt  = (h_q != 4'd0) ? 2'd3 : (t_q != 4'd0) ? 2'd2 : 2'd1;
    assign d2   = h_q;
    assign d1   = t_q;
    assign d0   = rem_q[3:0];

endmodule

// File: rtl/mat_uart_tx_fmt.sv
// mat_uart_tx_fmt: streams a stored matrix to the UART as decimal ASCII text
// Optional MAT_TX_SIGNED_EN: elements are two's complement and negatives get a leading '-'.
module mat_uart_tx_fmt
    import mat_uart_tx_fmt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              slot,
    input  logic [3:0]        m,
    input  logic [3:0]        n,
    output logic              busy,
    output logic              done,
    output logic              err,
    mat_uart_tx_fmt_if.master bus
);

    state_t     state_q, state_d;
    logic       slot_q, slot_d, neg_q, neg_d, sent_q, sent_d, err_q, err_d;
    logic [3:0] m_q, m_d, n_q, n_d, row_q, row_d, col_q, col_d;
    logic [2:0] idx_q, idx_d, n_ch, k;
    logic [7:0] tx_data_q, tx_data_d, mag, ch, cur_byte;
    logic [3:0] d2, d1, d0, dig;
    logic [1:0] cv_cnt;
    logic       cv_done, sgn, legal, issue;

`ifdef MAT_TX_SIGNED_EN
    assign sgn = bus.rd_data[7];
`else
    assign sgn = 1'b0;
`endif
    assign mag   = sgn ? (~bus.rd_data[7:0] + 8'd1) : bus.rd_data[7:0];
    assign legal = (m != 4'd0) && (m <= MAX_DIM) && (n != 4'd0) && (n <= MAX_DIM);

    mat_uart_tx_fmt_bin2dec_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (state_q == RDWAIT),
        .din   (mag),
        .done  (cv_done),
        .cnt   (cv_cnt),
        .d2    (d2),
        .d1    (d1),
        .d0    (d0)
    );

    // state register and latched transfer context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            slot_q    <= 1'b0;
            m_q       <= 4'd0;
            n_q       <= 4'd0;
            row_q     <= 4'd0;
            col_q     <= 4'd0;
            idx_q     <= 3'd0;
            neg_q     <= 1'b0;
            sent_q    <= 1'b0;
            tx_data_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            m_q       <= m_d;
            n_q       <= n_d;
            row_q     <= row_d;
            col_q     <= col_d;
            idx_q     <= idx_d;
            neg_q     <= neg_d;
            sent_q    <= sent_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
        end
    end

    // next state; SEP/CR/LF use sent_q to split "issue byte" from "wait for tx_done"
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        m_d       = m_q;
        n_d       = n_q;
        row_d     = row_q;
        col_d     = col_q;
        idx_d     = idx_q;
        neg_d     = neg_q;
        sent_d    = sent_q;
        tx_data_d = bus.tx_data;
        err_d     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (legal) begin
                    slot_d  = slot;
                    m_d     = m;
                    n_d     = n;
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                    state_d = FETCH;
                end else begin
                    err_d = 1'b1;
                end
            end
            FETCH:  state_d = RDWAIT;
            RDWAIT: begin
                neg_d   = sgn;
                idx_d   = 3'd0;
                state_d = CONV;
            end
            CONV:   if (cv_done) state_d = EMIT;
            EMIT:   begin
                idx_d   = idx_q + 3'd1;
                state_d = TXWAIT;
            end
            TXWAIT: if (bus.tx_done)
                state_d = (idx_q < n_ch) ? EMIT : (col_q < n_q - 4'd1) ? SEP : CR;
            SEP, CR, LF: begin
                sent_d = !(sent_q && bus.tx_done);
                if (sent_q && bus.tx_done) begin
                    state_d = (state_q == SEP) ? FETCH : (state_q == CR) ? LF :
                              (row_q < m_q - 4'd1) ? FETCH : FIN;
                    col_d   = (state_q == SEP) ? col_q + 4'd1 : (state_q == LF) ? 4'd0 : col_q;
                    row_d   = (state_q == LF && row_q < m_q - 4'd1) ? row_q + 4'd1 : row_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            sent_d  = 1'b0;
        end
    end

    // outputs: pick the pending character, launch bytes, drive the read port
    always_comb begin
        n_ch           = {1'b0, cv_cnt} + {2'b0, neg_q};
        k              = idx_q - {2'b0, neg_q} + 3'd3 - {1'b0, cv_cnt};
        dig            = (k == 3'd0) ? d2 : (k == 3'd1) ? d1 : d0;
        ch             = (neg_q && idx_q == 3'd0) ? ASC_MINUS : ASC_ZERO + {4'h0, dig};
        cur_byte       = (state_q == EMIT) ? ch : (state_q == SEP) ? ASC_SP :
                         (state_q == CR) ? ASC_CR : ASC_LF;
        issue          = !abort && (state_q == EMIT ||
                         ((state_q == SEP || state_q == CR || state_q == LF) && !sent_q));
        bus.tx_start   = issue;
        bus.tx_data    = issue ? cur_byte : tx_data_q;
        bus.rd_en      = !abort && (state_q == FETCH);
        bus.rd_slot    = slot_q;
        bus.rd_row     = row_q;
        bus.rd_col     = col_q;
        busy           = !abort && state_q != IDLE && state_q != FIN;
        done           = (state_q == FIN);
        err            = err_q;
    end

endmodule
